// File: rtl/ecap5_dwbgpio_if.sv
// rtl/ecap5_dwbgpio_if.sv - Wishbone pipelined bus bundle for the GPIO slave
interface ecap5_dwbgpio_if;
  logic [31:0] wb_adr_i;
  logic [31:0] wb_dat_i;
  logic [31:0] wb_dat_o;
  logic [3:0]  wb_sel_i;
  logic        wb_we_i;
  logic        wb_stb_i;
  logic        wb_ack_o;
  logic        wb_cyc_i;
  logic        wb_stall_o;

  modport master (
    output wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_stb_i, wb_cyc_i,
    input  wb_dat_o, wb_ack_o, wb_stall_o
  );

  modport slave (
    input  wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_stb_i, wb_cyc_i,
    output wb_dat_o, wb_ack_o, wb_stall_o
  );
endinterface

// File: rtl/ecap5_dwbgpio.sv
// rtl/ecap5_dwbgpio.sv - Wishbone GPIO slave: LEDs, debounced buttons, edge flags, irq
module ecap5_dwbgpio #(
  parameter int DEBOUNCE_CYCLES = 240000
) (
  input  logic             clk_i,
  input  logic             rst_i,
  ecap5_dwbgpio_if.slave   wb,
  input  logic             button0_i,
  input  logic             button1_i,
  output logic             led0_o,
  output logic             led1_o,
  output logic             irq_o
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       out_q, out_d;
  logic [1:0]       irq_en_q, irq_en_d;
  logic [1:0]       flags_q, flags_d;
  logic [1:0]       sync1_q, sync1_d;
  logic [1:0]       sync2_q, sync2_d;
  logic [1:0]       deb_q, deb_d;
  logic [CNT_W-1:0] cnt_q [2];
  logic [CNT_W-1:0] cnt_d [2];
  logic             ack_q, ack_d;
  logic [31:0]      dat_q, dat_d;
  logic             irq_q, irq_d;

  logic             accept;
  logic             wr;
  logic [1:0]       rise;
  logic [1:0]       clr;

  always_comb begin
    accept   = wb.wb_cyc_i & wb.wb_stb_i;
    wr       = accept & wb.wb_we_i & wb.wb_sel_i[0];
    sync1_d  = {button1_i, button0_i};
    sync2_d  = sync1_q;
    deb_d    = deb_q;
    cnt_d[0] = cnt_q[0];
    cnt_d[1] = cnt_q[1];

    // Any disagreement shorter than the full window restarts the count.
    for (int i = 0; i < 2; i++) begin
      if (sync2_q[i] == deb_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_LAST) begin
        deb_d[i] = sync2_q[i];
        cnt_d[i] = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end

    rise     = deb_d & ~deb_q;
    clr      = (wr && wb.wb_adr_i[3:2] == 2'd2) ? wb.wb_dat_i[1:0] : 2'b00;
    // A rising edge on the same edge as a clear wins.
    flags_d  = (flags_q & ~clr) | rise;
    out_d    = (wr && wb.wb_adr_i[3:2] == 2'd0) ? wb.wb_dat_i[1:0] : out_q;
    irq_en_d = (wr && wb.wb_adr_i[3:2] == 2'd3) ? wb.wb_dat_i[1:0] : irq_en_q;

    ack_d = accept;
    dat_d = 32'd0;
    if (accept && !wb.wb_we_i) begin
      case (wb.wb_adr_i[3:2])
        2'd0:    dat_d = {30'd0, out_q};
        2'd1:    dat_d = {30'd0, deb_q};
        2'd2:    dat_d = {30'd0, flags_q};
        default: dat_d = {30'd0, irq_en_q};
      endcase
    end

    irq_d = |(flags_q & irq_en_q);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      out_q    <= '0;
      irq_en_q <= '0;
      flags_q  <= '0;
      sync1_q  <= '0;
      sync2_q  <= '0;
      deb_q    <= '0;
      cnt_q[0] <= '0;
      cnt_q[1] <= '0;
      ack_q    <= 1'b0;
      dat_q    <= '0;
      irq_q    <= 1'b0;
    end else begin
      out_q    <= out_d;
      irq_en_q <= irq_en_d;
      flags_q  <= flags_d;
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      deb_q    <= deb_d;
      cnt_q[0] <= cnt_d[0];
      cnt_q[1] <= cnt_d[1];
      ack_q    <= ack_d;
      dat_q    <= dat_d;
      irq_q    <= irq_d;
    end
  end

  assign wb.wb_ack_o   = ack_q;
  assign wb.wb_dat_o   = dat_q;
  assign wb.wb_stall_o = 1'b0;
  assign led0_o        = out_q[0];
  assign led1_o        = out_q[1];
  assign irq_o         = irq_q;

  logic unused_bits;
  assign unused_bits = &{1'b0, wb.wb_adr_i[31:4], wb.wb_adr_i[1:0],
                         wb.wb_dat_i[31:2], wb.wb_sel_i[3:1]};

endmodule

// File: tb/tb_ecap5_dwbgpio.sv
// tb/tb_ecap5_dwbgpio.sv - directed vector bench for ecap5_dwbgpio
module tb_ecap5_dwbgpio;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic button0 = 1'b0;
  logic button1 = 1'b0;
  logic led0, led1, irq;
  int   n_vec = 0;
  int   n_err = 0;

  ecap5_dwbgpio_if bus_if ();

  ecap5_dwbgpio #(.DEBOUNCE_CYCLES(4)) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .wb        (bus_if),
    .button0_i (button0),
    .button1_i (button1),
    .led0_o    (led0),
    .led1_o    (led1),
    .irq_o     (irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic [31:0] exp_rd;
    logic [1:0]  exp_led;
  } vec_t;

  vec_t vt [14];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic idle_bus();
    bus_if.wb_cyc_i = 1'b0;
    bus_if.wb_stb_i = 1'b0;
    bus_if.wb_we_i  = 1'b0;
  endtask

  task automatic drive(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                       input logic [3:0] sel);
    bus_if.wb_cyc_i = 1'b1;
    bus_if.wb_stb_i = 1'b1;
    bus_if.wb_we_i  = we;
    bus_if.wb_adr_i = adr;
    bus_if.wb_dat_i = dat;
    bus_if.wb_sel_i = sel;
  endtask

  task automatic wr(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel,
                    input string name);
    drive(1'b1, adr, dat, sel);
    tick();
    idle_bus();
    chk({name, " ack"}, {31'd0, bus_if.wb_ack_o}, 32'd1);
  endtask

  task automatic rd(input logic [31:0] adr, input logic [31:0] exp, input string name);
    drive(1'b0, adr, 32'd0, 4'hF);
    tick();
    idle_bus();
    chk({name, " ack"}, {31'd0, bus_if.wb_ack_o}, 32'd1);
    chk({name, " data"}, bus_if.wb_dat_o, exp);
  endtask

  initial begin
    //       we    adr          dat            sel   exp_rd  exp_led
    vt[0]  = '{1'b1, 32'h0,     32'h3,         4'h1, 32'h0, 2'b11};
    vt[1]  = '{1'b0, 32'h0,     32'h0,         4'hF, 32'h3, 2'b11};
    vt[2]  = '{1'b1, 32'h0,     32'h0,         4'h2, 32'h0, 2'b11};
    vt[3]  = '{1'b0, 32'h0,     32'h0,         4'hF, 32'h3, 2'b11};
    vt[4]  = '{1'b0, 32'h4,     32'h0,         4'hF, 32'h0, 2'b11};
    vt[5]  = '{1'b0, 32'h8,     32'h0,         4'hF, 32'h0, 2'b11};
    vt[6]  = '{1'b1, 32'hC,     32'hFFFFFFFF,  4'h1, 32'h0, 2'b11};
    vt[7]  = '{1'b0, 32'hC,     32'h0,         4'hF, 32'h3, 2'b11};
    vt[8]  = '{1'b1, 32'hC,     32'h0,         4'h1, 32'h0, 2'b11};
    vt[9]  = '{1'b0, 32'hC,     32'h0,         4'hF, 32'h0, 2'b11};
    vt[10] = '{1'b0, 32'h3FF0,  32'h0,         4'hF, 32'h3, 2'b11};
    vt[11] = '{1'b1, 32'h3FF2,  32'h1,         4'h1, 32'h0, 2'b01};
    vt[12] = '{1'b0, 32'h1,     32'h0,         4'hF, 32'h1, 2'b01};
    vt[13] = '{1'b1, 32'h0,     32'hFFFFFFFC,  4'hF, 32'h0, 2'b00};

    bus_if.wb_adr_i = '0;
    bus_if.wb_dat_i = '0;
    bus_if.wb_sel_i = '0;
    idle_bus();

    // Reset state
    tick();
    tick();
    chk("rst ack",   {31'd0, bus_if.wb_ack_o},   32'd0);
    chk("rst dat",   bus_if.wb_dat_o,            32'd0);
    chk("rst leds",  {30'd0, led1, led0},        32'd0);
    chk("rst irq",   {31'd0, irq},               32'd0);
    chk("rst stall", {31'd0, bus_if.wb_stall_o}, 32'd0);
    rst = 1'b0;
    tick();

    // Register access table
    for (int i = 0; i < 14; i++) begin
      drive(vt[i].we, vt[i].adr, vt[i].dat, vt[i].sel);
      tick();
      idle_bus();
      chk($sformatf("vec%0d ack", i), {31'd0, bus_if.wb_ack_o}, 32'd1);
      if (!vt[i].we) chk($sformatf("vec%0d rdata", i), bus_if.wb_dat_o, vt[i].exp_rd);
      chk($sformatf("vec%0d leds", i), {30'd0, led1, led0}, {30'd0, vt[i].exp_led});
      tick();
      chk($sformatf("vec%0d ack drop", i), {31'd0, bus_if.wb_ack_o}, 32'd0);
    end

    // Debounce latency observed through the irq: flag at edge 5, irq at edge 6
    wr(32'hC, 32'h1, 4'h1, "en0");
    button0 = 1'b1;
    for (int k = 0; k <= 6; k++) begin
      tick();
      chk($sformatf("deb irq edge%0d", k), {31'd0, irq}, (k == 6) ? 32'd1 : 32'd0);
    end
    rd(32'h4, 32'h1, "in after press");
    rd(32'h8, 32'h1, "flags after press");

    // W1C clears flag, irq drops one cycle later
    wr(32'h8, 32'h1, 4'h1, "w1c0");
    tick();
    chk("irq after w1c", {31'd0, irq}, 32'd0);
    rd(32'h8, 32'h0, "flags after w1c");

    // Falling edge sets nothing
    button0 = 1'b0;
    repeat (10) tick();
    rd(32'h8, 32'h0, "flags after fall");
    rd(32'h4, 32'h0, "in after fall");

    // 3-cycle glitch is rejected
    button0 = 1'b1;
    repeat (3) tick();
    button0 = 1'b0;
    repeat (10) tick();
    rd(32'h4, 32'h0, "in after glitch");
    rd(32'h8, 32'h0, "flags after glitch");

    // Button1 edge with its irq disabled
    button1 = 1'b1;
    repeat (10) tick();
    chk("irq masked b1", {31'd0, irq}, 32'd0);
    rd(32'h8, 32'h2, "flags b1");
    rd(32'h4, 32'h2, "in b1");
    wr(32'h8, 32'h2, 4'h1, "w1c1");
    rd(32'h8, 32'h0, "flags b1 cleared");

    // W1C on the very edge deb0 rises: set wins
    button0 = 1'b1;
    repeat (5) tick();
    wr(32'h8, 32'h1, 4'h1, "w1c collide");
    rd(32'h8, 32'h1, "flags collide");
    wr(32'h8, 32'h1, 4'h1, "w1c after collide");
    rd(32'h8, 32'h0, "flags after clear");

    // Four back-to-back requests
    wr(32'hC, 32'h0, 4'h1, "en off");
    drive(1'b1, 32'h0, 32'h2, 4'h1);
    tick();
    chk("pipe0 ack", {31'd0, bus_if.wb_ack_o}, 32'd1);
    chk("pipe0 stall", {31'd0, bus_if.wb_stall_o}, 32'd0);
    drive(1'b0, 32'h0, 32'h0, 4'hF);
    tick();
    chk("pipe1 ack", {31'd0, bus_if.wb_ack_o}, 32'd1);
    chk("pipe1 data", bus_if.wb_dat_o, 32'h2);
    chk("pipe1 stall", {31'd0, bus_if.wb_stall_o}, 32'd0);
    drive(1'b0, 32'h4, 32'h0, 4'hF);
    tick();
    chk("pipe2 ack", {31'd0, bus_if.wb_ack_o}, 32'd1);
    chk("pipe2 data", bus_if.wb_dat_o, 32'h3);
    drive(1'b0, 32'hC, 32'h0, 4'hF);
    tick();
    idle_bus();
    chk("pipe3 ack", {31'd0, bus_if.wb_ack_o}, 32'd1);
    chk("pipe3 data", bus_if.wb_dat_o, 32'h0);
    chk("pipe leds", {30'd0, led1, led0}, 32'h2);
    tick();
    chk("pipe ack drop", {31'd0, bus_if.wb_ack_o}, 32'd0);

    // Asynchronous reset in the middle of an ack with irq active
    button0 = 1'b0;
    button1 = 1'b0;
    repeat (10) tick();
    button0 = 1'b1;
    button1 = 1'b1;
    repeat (10) tick();
    wr(32'h0, 32'h3, 4'h1, "pre out");
    wr(32'hC, 32'h3, 4'h1, "pre en");
    tick();
    tick();
    chk("pre irq", {31'd0, irq}, 32'd1);
    rd(32'h8, 32'h3, "pre flags");
    #2;
    rst = 1'b1;
    #1;
    chk("async ack",  {31'd0, bus_if.wb_ack_o}, 32'd0);
    chk("async dat",  bus_if.wb_dat_o,          32'd0);
    chk("async leds", {30'd0, led1, led0},      32'd0);
    chk("async irq",  {31'd0, irq},             32'd0);
    button0 = 1'b0;
    button1 = 1'b0;
    tick();
    rst = 1'b0;
    rd(32'h4, 32'h0, "post in");
    rd(32'h0, 32'h0, "post out");
    rd(32'h8, 32'h0, "post flags");
    rd(32'hC, 32'h0, "post en");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
